// File: rtl/vga_fb_arbiter_if.sv
// Host-write / clear / frame-buffer RAM bundle for vga_fb_arbiter.
// master = host + RAM side, slave = the arbiter.
interface vga_fb_arbiter_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_addr;
    logic [11:0] wr_data;
    logic        clr_req;
    logic [11:0] clr_color;
    logic        clr_busy;
    logic        ram_en;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [11:0] ram_wdata;
    logic [11:0] ram_rdata;

    modport master (
        output wr_valid, wr_addr, wr_data, clr_req, clr_color, ram_rdata,
        input  wr_ready, clr_busy, ram_en, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, clr_req, clr_color, ram_rdata,
        output wr_ready, clr_busy, ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: VGA scan-out reads on every 4th active pixel,
// host FIFO writes and a fill (clear) engine use all remaining cycles.
module vga_fb_arbiter #(
    parameter int FB_W     = 256,
    parameter int FB_WORDS = 49152,
    parameter int FIFO_D   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [10:0]           countX_i,
    input  logic [9:0]            countY_i,
    output logic [11:0]           pixel_o,
    vga_fb_arbiter_if.slave       bus
);

    localparam int          XB        = $clog2(FB_W);
    localparam int          AW        = $clog2(FIFO_D);
    localparam logic [15:0] LAST_ADDR = 16'(FB_WORDS - 1);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [11:0] data;
    } wr_ent_t;

    // ---------------- slot decode ----------------
    logic        active;
    logic        slot;
    logic [15:0] disp_addr;

    assign active    = (countX_i < 11'd1024) && (countY_i < 10'd768);
    assign slot      = active && (countX_i[1:0] == 2'b00);
    assign disp_addr = 16'({countY_i[9:2], countX_i[XB+1:2]});

    // ---------------- host write FIFO ----------------
    wr_ent_t     fifo_q [FIFO_D];
    logic [AW:0] wptr_q, rptr_q, wptr_d, rptr_d;
    logic        wr_ready_q;
    logic        push, pop, empty, full_d;
    wr_ent_t     head;

    assign empty  = (wptr_q == rptr_q);
    assign head   = fifo_q[rptr_q[AW-1:0]];
    assign push   = bus.wr_valid && wr_ready_q;
    assign wptr_d = wptr_q + (AW+1)'(push);
    assign rptr_d = rptr_q + (AW+1)'(pop);
    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full_d = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);

    assign bus.wr_ready = wr_ready_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            wr_ready_q <= 1'b1;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            wr_ready_q <= !full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wptr_q[AW-1:0]] <= '{addr: bus.wr_addr, data: bus.wr_data};
    end

    // ---------------- clear FSM ----------------
    state_t      state_q;
    logic [15:0] clr_addr_q;
    logic [11:0] clr_color_q;
    logic        clr_busy_q;
    logic        clr_wr;

    assign bus.clr_busy = clr_busy_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            clr_addr_q  <= '0;
            clr_color_q <= '0;
            clr_busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.clr_req) begin
                        state_q     <= S_CLEAR;
                        clr_addr_q  <= '0;
                        clr_color_q <= bus.clr_color;
                        clr_busy_q  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (clr_wr) begin
                        if (clr_addr_q == LAST_ADDR) begin
                            state_q    <= S_IDLE;
                            clr_busy_q <= 1'b0;
                        end else begin
                            clr_addr_q <= clr_addr_q + 16'd1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // ---------------- RAM port arbitration ----------------
    // Display owns the port on its slots; the host side never stalls it.
    always_comb begin
        bus.ram_en    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        pop           = 1'b0;
        clr_wr        = 1'b0;
        if (slot) begin
            bus.ram_en   = 1'b1;
            bus.ram_addr = disp_addr;
        end else if (state_q == S_CLEAR) begin
            bus.ram_en    = 1'b1;
            bus.ram_we    = 1'b1;
            bus.ram_addr  = clr_addr_q;
            bus.ram_wdata = clr_color_q;
            clr_wr        = 1'b1;
        end else if (!empty) begin
            pop = 1'b1;
            // Out-of-range entries are consumed without touching the RAM.
            if (head.addr <= LAST_ADDR) begin
                bus.ram_en    = 1'b1;
                bus.ram_we    = 1'b1;
                bus.ram_addr  = head.addr;
                bus.ram_wdata = head.data;
            end
        end
    end

    // ---------------- pixel path ----------------
    logic        rd_s1_q;
    logic [1:0]  disp_pipe_q;
    logic [11:0] pix_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_s1_q     <= 1'b0;
            disp_pipe_q <= '0;
            pix_q       <= '0;
        end else begin
            rd_s1_q     <= slot;
            disp_pipe_q <= {disp_pipe_q[0], active};
            if (rd_s1_q) pix_q <= bus.ram_rdata;
        end
    end

    assign pixel_o = disp_pipe_q[1] ? pix_q : 12'h000;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: RAM model, write scoreboard and pixel scoreboard.
module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] cx;
    logic [9:0]  cy;
    logic [11:0] pixel;

    vga_fb_arbiter_if bus();

    vga_fb_arbiter #(.FB_W(256), .FB_WORDS(49152), .FIFO_D(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .countX_i (cx),
        .countY_i (cy),
        .pixel_o  (pixel),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM, read data one cycle after the access.
    logic [11:0] ram [0:65535];
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata     <= ram[bus.ram_addr];
        end
    end

    typedef struct {
        logic [15:0] addr;
        logic [11:0] data;
    } wexp_t;

    wexp_t       wq [$];
    logic [11:0] pq [$];
    logic [11:0] model_mem [0:65535];
    logic [11:0] last_rd;
    int          ncmp = 0;
    int          nmis = 0;
    logic        s_busy, s_slot;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_w(input logic [15:0] a, input logic [11:0] d);
        wexp_t e;
        e.addr = a;
        e.data = d;
        wq.push_back(e);
    endtask

    // Negedge half: sample, run write and pixel scoreboards.
    task automatic half();
        wexp_t       e;
        logic [11:0] ep;
        logic        act;
        @(negedge clk);
        act    = (cx < 11'd1024) && (cy < 10'd768);
        s_slot = act && (cx[1:0] == 2'b00);
        s_busy = bus.clr_busy;
        if (rst && bus.ram_en && bus.ram_we) begin
            chk("wr_expected", 32'(wq.size() != 0), 32'd1);
            if (wq.size() != 0) begin
                e = wq.pop_front();
                chk("wr_addr", bus.ram_addr, e.addr);
                chk("wr_data", bus.ram_wdata, e.data);
                model_mem[e.addr] = e.data;
            end
        end
        if (!rst) begin
            pq.delete();
            pq.push_back(12'h000);
            pq.push_back(12'h000);
            last_rd = 12'h000;
        end else begin
            if (s_slot) last_rd = model_mem[{cy[9:2], cx[9:2]}];
            pq.push_back(act ? last_rd : 12'h000);
            ep = pq.pop_front();
            chk("pixel", pixel, ep);
        end
    endtask

    task automatic fin();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        half();
        fin();
    endtask

    task automatic blank();
        cx = 11'd1100;
        cy = 10'd780;
    endtask

    initial begin
        int  hs;
        logic done;
        rst = 1'b0;
        blank();
        bus.wr_valid  = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.clr_req   = 1'b0;
        bus.clr_color = '0;
        last_rd = '0;

        // T1: reset state
        for (int i = 0; i < 3; i++) begin
            half();
            chk("t1_pixel", pixel, 12'h000);
            chk("t1_busy", bus.clr_busy, 1'b0);
            chk("t1_ready", bus.wr_ready, 1'b1);
            chk("t1_ram_en", bus.ram_en, 1'b0);
            fin();
        end
        rst = 1'b1;
        cyc();

        // T2: host write then scan-out of the same location
        bus.wr_valid = 1'b1; bus.wr_addr = 16'h0101; bus.wr_data = 12'hABC;
        push_w(16'h0101, 12'hABC);
        cyc();
        bus.wr_valid = 1'b0;
        cyc();
        cy = 10'd4; cx = 11'd4;
        half();
        chk("t2_ram_en", bus.ram_en, 1'b1);
        chk("t2_ram_we", bus.ram_we, 1'b0);
        chk("t2_ram_addr", bus.ram_addr, 16'h0101);
        fin();
        for (int x = 5; x < 8; x++) begin cx = 11'(x); cyc(); end
        blank();
        for (int i = 0; i < 4; i++) cyc();

        // T3: FIFO fills while display holds the port
        cy = 10'd4; cx = 11'd4;
        for (int i = 0; i < 7; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 16'h0010 + 16'(i < 4 ? i : 4);
            bus.wr_data  = 12'h100 + 12'(i < 4 ? i : 4);
            half();
            chk("t3_ready", bus.wr_ready, 1'(i < 4));
            if (i < 4) push_w(16'h0010 + 16'(i), 12'h100 + 12'(i));
            fin();
        end
        bus.wr_valid = 1'b0;
        blank();
        for (int i = 0; i < 6; i++) cyc();
        chk("t3_drained", 32'(wq.size()), 32'd0);
        chk("t3_ready_back", bus.wr_ready, 1'b1);

        // T4: full clear with a queued write landing afterwards
        for (int a = 0; a < 49152; a++) push_w(16'(a), 12'h0F0);
        bus.clr_req = 1'b1; bus.clr_color = 12'h0F0;
        half();
        chk("t4_busy_req_cycle", bus.clr_busy, 1'b0);
        fin();
        bus.clr_req = 1'b0;
        hs = 0;
        done = 1'b0;
        for (int k = 0; k < 50000; k++) begin
            if (k >= 2 && k < 5) begin cx = 11'd0; cy = 10'd0; end
            else blank();
            bus.wr_valid = (k == 10);
            bus.wr_addr  = 16'h0005;
            bus.wr_data  = 12'h555;
            bus.clr_req  = (k == 20);
            bus.clr_color = (k == 20) ? 12'hFFF : 12'h0F0;
            if (k == 10) push_w(16'h0005, 12'h555);
            half();
            if (k == 10) chk("t4_ready_in_clear", bus.wr_ready, 1'b1);
            if (s_busy && !s_slot) hs++;
            done = !s_busy;
            fin();
            if (done) break;
        end
        bus.wr_valid = 1'b0; bus.clr_req = 1'b0;
        chk("t4_clear_ended", done, 1'b1);
        chk("t4_busy_slots", hs, 49152);
        for (int i = 0; i < 4; i++) cyc();
        chk("t4_queue_empty", 32'(wq.size()), 32'd0);

        // T5: out-of-range write is popped silently, last valid address is written
        bus.wr_valid = 1'b1; bus.wr_addr = 16'hC000; bus.wr_data = 12'h777;
        cyc();
        bus.wr_valid = 1'b0;
        half();
        chk("t5_ram_en", bus.ram_en, 1'b0);
        chk("t5_ready", bus.wr_ready, 1'b1);
        fin();
        half();
        chk("t5_ram_en_after", bus.ram_en, 1'b0);
        fin();
        bus.wr_valid = 1'b1; bus.wr_addr = 16'hBFFF; bus.wr_data = 12'h321;
        push_w(16'hBFFF, 12'h321);
        cyc();
        bus.wr_valid = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        chk("t5_queue_empty", 32'(wq.size()), 32'd0);

        // T6: reset in the middle of a clear with writes queued
        for (int a = 0; a < 1000; a++) push_w(16'(a), 12'h00F);
        bus.clr_req = 1'b1; bus.clr_color = 12'h00F;
        cyc();
        bus.clr_req = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            bus.wr_valid = (k < 2);
            bus.wr_addr  = 16'h0020 + 16'(k);
            bus.wr_data  = 12'hEEE;
            cyc();
        end
        bus.wr_valid = 1'b0;
        rst = 1'b0;
        half();
        chk("t6_busy", bus.clr_busy, 1'b0);
        chk("t6_ready", bus.wr_ready, 1'b1);
        chk("t6_ram_en", bus.ram_en, 1'b0);
        chk("t6_pixel", pixel, 12'h000);
        chk("t6_clear_writes_done", 32'(wq.size()), 32'd0);
        fin();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        chk("t6_busy_after", bus.clr_busy, 1'b0);
        chk("t6_ready_after", bus.wr_ready, 1'b1);
        cy = 10'd0;
        for (int x = 0; x < 4; x++) begin cx = 11'(x); cyc(); end
        blank();
        for (int i = 0; i < 3; i++) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
        $finish;
    end

endmodule
